// File: rtl/serdes_lane_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serdes_lane_aligner                                          |
// | Description : Transposes the lane-interleaved ISERDES word into per-lane   |
// |               BITS-wide words and word-aligns each lane by bit-slipping    |
// |               against a training pattern, reporting lock / fail status.    |
// |               Optional lock monitor: define SERDES_LOCK_MONITOR_EN to      |
// |               drop lock (and pulse o_lock_lost) on a mismatching training  |
// |               word while locked.                                           |
// | Revision    : 1.0 - initial parametrised release                           |
// +----------------------------------------------------------------------------+
module serdes_lane_aligner #(
  parameter int              LANES          = 8,
  parameter int              BITS           = 8,
  parameter logic [BITS-1:0] TRAIN_PATTERN  = 8'hA5,
  parameter int              MATCH_COUNT    = 4,
  parameter int              SEARCH_TIMEOUT = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_valid,
  input  logic [LANES*BITS-1:0]           i_lvds,
  input  logic                            i_align_start,
  input  logic                            i_train,
  output logic                            o_valid,
  output logic [LANES*BITS-1:0]           o_data,
  output logic [LANES*$clog2(BITS)-1:0]   o_offset,
  output logic [LANES-1:0]                o_locked,
  output logic                            o_all_locked,
  output logic [LANES-1:0]                o_fail,
  output logic [LANES-1:0]                o_lock_lost
);

  localparam int OFF_W = $clog2(BITS);
  localparam int MC_W  = $clog2(MATCH_COUNT + 1);
  localparam int TO_W  = $clog2(SEARCH_TIMEOUT + 1);

  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(BITS - 1);
  localparam logic [MC_W-1:0]  MC_MAX  = MC_W'(MATCH_COUNT);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(SEARCH_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } state_e;

  // Pipeline valid flags: stage 1 (history registers) and stage 2 (outputs).
  logic valid1_q, valid1_d;
  logic valid2_q, valid2_d;
  logic all_locked_q, all_locked_d;

  // Next-cycle lock of every lane, so the global flag registers alongside o_locked.
  logic [LANES-1:0] locked_nxt;

  // Valid pipeline and global lock next-state.
  always_comb begin
    valid1_d     = i_valid;
    valid2_d     = valid1_q;
    all_locked_d = &locked_nxt;
  end

  // Valid pipeline and global lock registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_q     <= 1'b0;
      valid2_q     <= 1'b0;
      all_locked_q <= 1'b0;
    end else begin
      valid1_q     <= valid1_d;
      valid2_q     <= valid2_d;
      all_locked_q <= all_locked_d;
    end
  end

  assign o_valid      = valid2_q;
  assign o_all_locked = all_locked_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BITS-1:0]   word_w;
    logic [2*BITS-1:0] window_w;
    logic [BITS-1:0]   aligned_w;
    logic              match_w;

    logic [BITS-1:0]  cur_q,    cur_d;
    logic [BITS-1:0]  prev_q,   prev_d;
    logic [BITS-1:0]  data_q,   data_d;
    state_e           state_q,  state_d;
    logic [OFF_W-1:0] offset_q, offset_d;
    logic [MC_W-1:0]  match_q,  match_d;
    logic [TO_W-1:0]  tmo_q,    tmo_d;
    logic             locked_q, locked_d;
    logic             fail_q,   fail_d;
`ifdef SERDES_LOCK_MONITOR_EN
    logic             lost_q,   lost_d;
`endif

    // Gather this lane's bits out of the interleaved word; the first serial
    // bit (k = 0) lands in the word MSB.
    always_comb begin
      word_w = '0;
      for (int k = 0; k < BITS; k++) begin
        word_w[BITS-1-k] = i_lvds[k*LANES + (LANES-1-l)];
      end
    end

    // Two-word history window and the slip-selected aligned word.
    always_comb begin
      window_w  = {prev_q, cur_q};
      aligned_w = window_w[offset_q +: BITS];
      match_w   = (aligned_w == TRAIN_PATTERN);
    end

    // Stage-1 history shift on each accepted word; stage-2 output capture.
    always_comb begin
      cur_d  = cur_q;
      prev_d = prev_q;
      data_d = data_q;
      if (i_valid) begin
        prev_d = cur_q;
        cur_d  = word_w;
      end
      if (valid1_q) begin
        data_d = aligned_w;
      end
    end

    // Alignment FSM next-state: restart has priority over any evaluation.
    always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      match_d  = match_q;
      tmo_d    = tmo_q;
`ifdef SERDES_LOCK_MONITOR_EN
      lost_d   = 1'b0;
`endif
      if (i_align_start) begin
        state_d  = ST_SEARCH;
        offset_d = '0;
        match_d  = '0;
        tmo_d    = '0;
      end else if (valid1_q) begin
        case (state_q)
          ST_SEARCH: begin
            if (tmo_q != TO_MAX) begin
              tmo_d = tmo_q + TO_W'(1);
            end
            if (i_train) begin
              if (match_w) begin
                if (match_q != MC_MAX) begin
                  match_d = match_q + MC_W'(1);
                end
              end else begin
                match_d  = '0;
                offset_d = (offset_q == OFF_MAX) ? '0 : offset_q + OFF_W'(1);
              end
            end
            // A lock on the final allowed word beats the timeout.
            if (match_d == MC_MAX) begin
              state_d = ST_LOCKED;
            end else if (tmo_d == TO_MAX) begin
              state_d = ST_FAIL;
            end
          end
          ST_LOCKED: begin
`ifdef SERDES_LOCK_MONITOR_EN
            // Keep the offset: a single bad word is usually a glitch, not a skew change.
            if (i_train && !match_w) begin
              state_d = ST_SEARCH;
              match_d = '0;
              tmo_d   = '0;
              lost_d  = 1'b1;
            end
`endif
          end
          default: begin
          end
        endcase
      end
      locked_d = (state_d == ST_LOCKED);
      fail_d   = (state_d == ST_FAIL);
    end

    // Lane state and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cur_q    <= '0;
        prev_q   <= '0;
        data_q   <= '0;
        state_q  <= ST_IDLE;
        offset_q <= '0;
        match_q  <= '0;
        tmo_q    <= '0;
        locked_q <= 1'b0;
        fail_q   <= 1'b0;
      end else begin
        cur_q    <= cur_d;
        prev_q   <= prev_d;
        data_q   <= data_d;
        state_q  <= state_d;
        offset_q <= offset_d;
        match_q  <= match_d;
        tmo_q    <= tmo_d;
        locked_q <= locked_d;
        fail_q   <= fail_d;
      end
    end

`ifdef SERDES_LOCK_MONITOR_EN
    // Lock-lost pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lost_q <= 1'b0;
      end else begin
        lost_q <= lost_d;
      end
    end
    assign o_lock_lost[l] = lost_q;
`else
    assign o_lock_lost[l] = 1'b0;
`endif

    assign locked_nxt[l]                 = locked_d;
    assign o_data[l*BITS +: BITS]        = data_q;
    assign o_offset[l*OFF_W +: OFF_W]    = offset_q;
    assign o_locked[l]                   = locked_q;
    assign o_fail[l]                     = fail_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_serdes_lane_aligner.sv
`timescale 1ns/1ps
module tb_serdes_lane_aligner;

  localparam int         NL  = 8;
  localparam int         NB  = 8;
  localparam logic [7:0] PAT = 8'hA5;
  localparam int         MC  = 4;
  localparam int         TO  = 16;

  localparam int M_IDLE = 0, M_SRCH = 1, M_LOCK = 2, M_FAIL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [63:0] i_lvds = '0;
  logic        i_align_start = 1'b0;
  logic        i_train = 1'b0;
  logic        o_valid;
  logic [63:0] o_data;
  logic [23:0] o_offset;
  logic [7:0]  o_locked;
  logic        o_all_locked;
  logic [7:0]  o_fail;
  logic [7:0]  o_lock_lost;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serdes_lane_aligner #(
    .LANES(NL), .BITS(NB), .TRAIN_PATTERN(PAT),
    .MATCH_COUNT(MC), .SEARCH_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_lvds(i_lvds),
    .i_align_start(i_align_start), .i_train(i_train),
    .o_valid(o_valid), .o_data(o_data), .o_offset(o_offset),
    .o_locked(o_locked), .o_all_locked(o_all_locked),
    .o_fail(o_fail), .o_lock_lost(o_lock_lost)
  );

  // Reference model state
  logic [7:0] m_cur [NL];
  logic [7:0] m_prev[NL];
  logic [7:0] m_data[NL];
  int         m_mode[NL], m_off[NL], m_mc[NL], m_tc[NL];
  logic [7:0] m_locked, m_fail, m_lost;
  logic       m_all, m_v1, m_v2;

  logic [7:0] lane_word[NL];
  int         sk[NL];
  int         lost_seen[NL];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] rotl(input logic [7:0] x, input int s);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < s; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic pack_lanes();
    logic [63:0] v;
    v = '0;
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < NB; k++)
        v[k*NL + (NL-1-l)] = lane_word[l][NB-1-k];
    i_lvds = v;
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_cur[l] = '0; m_prev[l] = '0; m_data[l] = '0;
      m_mode[l] = M_IDLE; m_off[l] = 0; m_mc[l] = 0; m_tc[l] = 0;
    end
    m_locked = '0; m_fail = '0; m_lost = '0; m_all = 1'b0;
    m_v1 = 1'b0; m_v2 = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0]  a[NL];
    logic [15:0] win;
    logic [7:0]  w;
    for (int l = 0; l < NL; l++) begin
      win  = {m_prev[l], m_cur[l]};
      a[l] = 8'(win >> m_off[l]);
    end
    for (int l = 0; l < NL; l++) begin
      m_lost[l] = 1'b0;
      if (i_align_start) begin
        m_mode[l] = M_SRCH; m_off[l] = 0; m_mc[l] = 0; m_tc[l] = 0;
      end else if (m_v1) begin
        if (m_mode[l] == M_SRCH) begin
          if (m_tc[l] < TO) m_tc[l]++;
          if (i_train) begin
            if (a[l] == PAT) m_mc[l]++;
            else begin m_mc[l] = 0; m_off[l] = (m_off[l] + 1) % NB; end
          end
          if (m_mc[l] >= MC) m_mode[l] = M_LOCK;
          else if (m_tc[l] >= TO) m_mode[l] = M_FAIL;
        end else if (m_mode[l] == M_LOCK) begin
`ifdef SERDES_LOCK_MONITOR_EN
          if (i_train && a[l] != PAT) begin
            m_mode[l] = M_SRCH; m_mc[l] = 0; m_tc[l] = 0; m_lost[l] = 1'b1;
          end
`endif
        end
      end
      m_locked[l] = (m_mode[l] == M_LOCK);
      m_fail[l]   = (m_mode[l] == M_FAIL);
    end
    m_all = &m_locked;
    for (int l = 0; l < NL; l++) if (m_v1) m_data[l] = a[l];
    m_v2 = m_v1;
    if (i_valid) begin
      for (int l = 0; l < NL; l++) begin
        for (int k = 0; k < NB; k++) w[NB-1-k] = i_lvds[k*NL + (NL-1-l)];
        m_prev[l] = m_cur[l];
        m_cur[l]  = w;
      end
    end
    m_v1 = i_valid;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] ed;
    logic [23:0] eo;
    for (int l = 0; l < NL; l++) begin
      ed[l*8 +: 8] = m_data[l];
      eo[l*3 +: 3] = 3'(m_off[l]);
    end
    chk("valid", o_valid, m_v2);
    chk("data", o_data, ed);
    chk("offset", o_offset, eo);
    chk("locked", o_locked, m_locked);
    chk("all_locked", o_all_locked, m_all);
    chk("fail", o_fail, m_fail);
    chk("lock_lost", o_lock_lost, m_lost);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    for (int l = 0; l < NL; l++) if (o_lock_lost[l] === 1'b1) lost_seen[l]++;
  endtask

  initial begin
    logic [23:0] eo;
    int cl, tot;
    model_reset();
    for (int l = 0; l < NL; l++) lost_seen[l] = 0;

    // Reset held with toggling inputs: everything stays at zero
    for (int c = 0; c < 4; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_lvds = {$urandom, $urandom};
      i_train = 1'($urandom_range(0, 1));
      i_align_start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_all();
    end
    i_align_start = 1'b0;
    #3 rst_n = 1'b1;

    // Idle pass-through at offset 0 with random data and valid
    for (int c = 0; c < 20; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_lvds = {$urandom, $urandom};
      i_train = 1'($urandom_range(0, 1));
      step();
    end

    // Directed transpose
    i_valid = 1'b1; i_lvds = 64'h0123456789ABCDEF;
    step();
    i_valid = 1'b0;
    step();
    chk("tr_valid", o_valid, 1'b1);
    chk("tr_lane0", o_data[7:0], 8'hF0);
    chk("tr_lane1", o_data[15:8], 8'hCC);
    chk("tr_lane7", o_data[63:56], 8'hFF);
    step();

    // Alignment: every lane skewed by 3 bits
    for (int l = 0; l < NL; l++) lane_word[l] = rotl(PAT, 3);
    pack_lanes();
    i_valid = 1'b1; i_train = 1'b1;
    repeat (3) step();
    i_align_start = 1'b1; step(); i_align_start = 1'b0;
    repeat (6) step();
    chk("al_not_yet", o_locked, 8'h00);
    step();
    chk("al_locked", o_locked, 8'hFF);
    repeat (3) step();
    chk("al_offset", o_offset, 24'h6DB6DB);
    chk("al_all", o_all_locked, 1'b1);
    chk("al_data", o_data, {8{PAT}});

    // Timeout on lane 2
    lane_word[2] = 8'h00;
    pack_lanes();
    repeat (2) step();
    i_align_start = 1'b1; step(); i_align_start = 1'b0;
    repeat (15) step();
    chk("to_early", o_fail, 8'h00);
    step();
    chk("to_fail", o_fail, 8'h04);
    chk("to_locked", o_locked, 8'hFB);
    chk("to_all", o_all_locked, 1'b0);

    // Restart mid-search at offset 5
    for (int l = 0; l < NL; l++) lane_word[l] = 8'h00;
    pack_lanes();
    repeat (2) step();
    i_align_start = 1'b1; step(); i_align_start = 1'b0;
    chk("rs_fail_clr", o_fail, 8'h00);
    repeat (5) step();
    chk("rs_off5", o_offset, 24'hB6DB6D);
    i_align_start = 1'b1; step(); i_align_start = 1'b0;
    chk("rs_off0", o_offset, 24'h0);
    chk("rs_locked", o_locked, 8'h00);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("ar_offset", o_offset, 24'h0);
    #3 rst_n = 1'b1;
    repeat (4) step();
    chk("ar_idle_off", o_offset, 24'h0);

    // Random skews, lock, then one corrupted training word on one lane
    eo = '0;
    for (int l = 0; l < NL; l++) begin
      sk[l] = $urandom_range(0, 7);
      lane_word[l] = rotl(PAT, sk[l]);
      eo[l*3 +: 3] = 3'(sk[l]);
    end
    pack_lanes();
    repeat (2) step();
    i_align_start = 1'b1; step(); i_align_start = 1'b0;
    repeat (16) step();
    chk("mon_offset", o_offset, eo);
    chk("mon_locked", o_locked, 8'hFF);
    for (int l = 0; l < NL; l++) lost_seen[l] = 0;
    cl = $urandom_range(0, 7);
    lane_word[cl] = lane_word[cl] ^ 8'h80;
    pack_lanes();
    step();
    lane_word[cl] = rotl(PAT, sk[cl]);
    pack_lanes();
    repeat (12) step();
    tot = 0;
    for (int l = 0; l < NL; l++) tot += lost_seen[l];
`ifdef SERDES_LOCK_MONITOR_EN
    chk("mon_lost_lane", lost_seen[cl], 1);
    chk("mon_lost_tot", tot, 1);
`else
    chk("mon_lost_lane", lost_seen[cl], 0);
    chk("mon_lost_tot", tot, 0);
`endif
    chk("mon_relock", o_locked, 8'hFF);
    chk("mon_same_off", o_offset, eo);

    // Random traffic with occasional corruption and restarts
    for (int c = 0; c < 150; c++) begin
      for (int l = 0; l < NL; l++)
        lane_word[l] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : rotl(PAT, sk[l]);
      pack_lanes();
      i_valid = ($urandom_range(0, 3) != 0);
      i_train = ($urandom_range(0, 7) != 0);
      i_align_start = ($urandom_range(0, 24) == 0);
      step();
    end
    i_align_start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
